// File: rtl/vga_serial_pkg.sv
// Shared definitions for the VGA serial-display frame buffer: frame geometry,
// the default frame-buffer depth and the writer FSM state type.
package vga_serial_pkg;

    typedef enum logic [2:0] {IDLE, LATCH, WRITE, INC, WAIT} wr_state_t;

    localparam int FRAME_W    = 1024;
    localparam int FRAME_H    = 768;
    localparam int FRAME_BITS = FRAME_W * FRAME_H * 3 * 8;

    // Words per frame for a given RAM word width; the reader uses the same expression.
    function automatic int frame_depth(input int ram_width);
        return FRAME_BITS / ram_width;
    endfunction

endpackage

// File: rtl/ram_writer.sv
// Write side of the frame buffer: packs UART bytes into RAM words (first byte in
// the LSBs) and writes them to consecutive addresses, wrapping once per frame.
module ram_writer
    import vga_serial_pkg::*;
#(
    parameter int  BYTE_WIDTH = 8,
    parameter int  RAM_WIDTH  = 8,
    parameter int  RAM_DEPTH  = frame_depth(RAM_WIDTH),
    localparam int ADDR_BITS  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    input  logic                  frame_restart,
    output logic [ADDR_BITS-1:0]  address,
    output logic [RAM_WIDTH-1:0]  data_out,
    output logic                  write_en,
    output logic                  frame_done,
    output logic                  busy,
    output wr_state_t             state
);

    localparam int BYTES_PER_WORD = RAM_WIDTH / BYTE_WIDTH;
    localparam int CNT_BITS       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_DEPTH - 1);
    localparam logic [CNT_BITS-1:0]  LAST_BYTE = CNT_BITS'(BYTES_PER_WORD - 1);

    wr_state_t             next_state;
    logic [CNT_BITS-1:0]   byte_cnt;
    logic [RAM_WIDTH-1:0]  word_buf;
    logic [RAM_WIDTH-1:0]  last_word;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (rx_ready) next_state = LATCH;
            LATCH:   next_state = (byte_cnt == LAST_BYTE) ? WRITE : WAIT;
            WRITE:   next_state = INC;
            INC:     next_state = WAIT;
            WAIT:    if (!rx_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A restart while rx_ready is still high parks in WAIT so the held byte is not reused.
        if (frame_restart) next_state = rx_ready ? WAIT : IDLE;
    end

    assign write_en   = (state == WRITE) && !rst && !frame_restart;
    assign frame_done = (state == INC) && (address == LAST_ADDR) && !rst && !frame_restart;
    assign busy       = (state != IDLE);
    // The completed word is presented during the write; otherwise the last written word holds.
    assign data_out   = (state == WRITE) ? word_buf : last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            address   <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            last_word <= '0;
        end else if (frame_restart) begin
            state    <= next_state;
            address  <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                LATCH: begin
                    for (int i = 0; i < BYTES_PER_WORD; i++) begin
                        if (byte_cnt == CNT_BITS'(i))
                            word_buf[i*BYTE_WIDTH +: BYTE_WIDTH] <= rx_data;
                    end
                    byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_BITS'(1);
                end
                WRITE: last_word <= word_buf;
                INC:   address <= (address == LAST_ADDR) ? '0 : address + ADDR_BITS'(1);
                default: ;
            endcase
        end
    end

endmodule
